// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with a post-reset clear of R0..R7.
// Define ROUND_ROBIN_EN for alternating priority on contention; otherwise A has strict priority.
module reg_write_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        A_Req,
  input  logic [2:0]  A_DR,
  input  logic [15:0] A_Data,
  output logic        A_Gnt,
  input  logic        B_Req,
  input  logic [2:0]  B_DR,
  input  logic [15:0] B_Data,
  output logic        B_Gnt,
  output logic [2:0]  DR,
  output logic [15:0] Data_In,
  output logic        LD_REG,
  output logic        Busy,
  output logic        Collision
);

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        contend;
  logic        prefer_b;
  logic        gnt_a, gnt_b;

`ifdef ROUND_ROBIN_EN
  // 0 selects A, 1 selects B when both request.
  logic ptr_q, ptr_d;
  assign prefer_b = ptr_q;
`else
  assign prefer_b = 1'b0;
`endif

  assign contend = A_Req & B_Req;
  assign gnt_a   = A_Req & (~B_Req | ~prefer_b);
  assign gnt_b   = B_Req & (~A_Req | prefer_b);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StArb;
        end
      end
      StArb: begin
        cnt_d = 3'd0;
      end
      default: begin
        state_d = StClear;
        cnt_d   = 3'd0;
      end
    endcase
  end

`ifdef ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    // Hand priority to the loser only when both actually competed.
    if (state_q == StArb && contend) begin
      ptr_d = gnt_a;
    end
  end
`endif

  always_comb begin
    A_Gnt     = 1'b0;
    B_Gnt     = 1'b0;
    DR        = 3'd0;
    Data_In   = 16'h0000;
    LD_REG    = 1'b0;
    Busy      = 1'b0;
    Collision = 1'b0;
    if (Reset) begin
      // Reset forces the Cnt=0 clear cycle regardless of the registered state.
      LD_REG = 1'b1;
      Busy   = 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          LD_REG = 1'b1;
          Busy   = 1'b1;
          DR     = cnt_q;
        end
        StArb: begin
          A_Gnt     = gnt_a;
          B_Gnt     = gnt_b;
          LD_REG    = gnt_a | gnt_b;
          Collision = contend & (A_DR == B_DR);
          if (gnt_a) begin
            DR      = A_DR;
            Data_In = A_Data;
          end else if (gnt_b) begin
            DR      = B_DR;
            Data_In = B_Data;
          end
        end
        default: begin
          LD_REG = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StClear;
      cnt_q   <= 3'd0;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter with a behavioural register file.
module tb_reg_write_arbiter;

  logic        clk;
  logic        Reset;
  logic        A_Req, B_Req;
  logic [2:0]  A_DR, B_DR;
  logic [15:0] A_Data, B_Data;
  logic        A_Gnt, B_Gnt, LD_REG, Busy, Collision;
  logic [2:0]  DR;
  logic [15:0] Data_In;
  logic [23:0] obs;
  logic [15:0] rf [8];
  logic        rf_poison;
  int          total = 0;
  int          bad = 0;

  reg_write_arbiter dut (
    .Clk       (clk),
    .Reset     (Reset),
    .A_Req     (A_Req),
    .A_DR      (A_DR),
    .A_Data    (A_Data),
    .A_Gnt     (A_Gnt),
    .B_Req     (B_Req),
    .B_DR      (B_DR),
    .B_Data    (B_Data),
    .B_Gnt     (B_Gnt),
    .DR        (DR),
    .Data_In   (Data_In),
    .LD_REG    (LD_REG),
    .Busy      (Busy),
    .Collision (Collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {A_Gnt, B_Gnt, LD_REG, Busy, Collision, DR, Data_In};

  // External register file; poisoned so the clear sequence is observable.
  always @(posedge clk) begin
    if (rf_poison) begin
      for (int r = 0; r < 8; r++) rf[r] <= 16'hDEAD;
    end else if (LD_REG) begin
      rf[DR] <= Data_In;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic test_reset();
    @(posedge clk); #1;
    A_Req = 1'b1; B_Req = 1'b1; A_DR = 3'd5; B_DR = 3'd5;
    A_Data = 16'h1111; B_Data = 16'h2222;
    @(negedge clk);
    total++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_with_req: got %h want %h", obs, {5'b00110, 3'd0, 16'h0000});
    end
    @(posedge clk); #1;
    A_Req = 1'b0; B_Req = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_idle: got %h want %h", obs, {5'b00110, 3'd0, 16'h0000});
    end
  endtask

  task automatic test_clear_seq();
    @(posedge clk); #1;
    Reset = 1'b0;
    rf_poison = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (obs !== {5'b00110, 3'(i), 16'h0000}) begin
        bad++;
        $display("FAIL clear_cycle%0d: got %h want %h", i, obs, {5'b00110, 3'(i), 16'h0000});
      end
    end
    @(negedge clk);
    total++;
    if (obs !== 24'h000000) begin
      bad++;
      $display("FAIL first_arb_idle: got %h want %h", obs, 24'h000000);
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (rf[r] !== 16'h0000) begin
        bad++;
        $display("FAIL cleared_r%0d: got %h want 0000", r, rf[r]);
      end
    end
  endtask

  task automatic test_single_a();
    @(posedge clk); #1;
    A_Req = 1'b1; A_DR = 3'd3; A_Data = 16'h1234;
    @(negedge clk);
    total++;
    if (obs !== {5'b10100, 3'd3, 16'h1234}) begin
      bad++;
      $display("FAIL single_a: got %h want %h", obs, {5'b10100, 3'd3, 16'h1234});
    end
    @(posedge clk); #1;
    A_Req = 1'b0;
    total++;
    if (rf[3] !== 16'h1234) begin
      bad++;
      $display("FAIL single_a_r3: got %h want 1234", rf[3]);
    end
  endtask

  task automatic test_single_b();
    @(posedge clk); #1;
    B_Req = 1'b1; B_DR = 3'd6; B_Data = 16'h5A5A;
    @(negedge clk);
    total++;
    if (obs !== {5'b01100, 3'd6, 16'h5A5A}) begin
      bad++;
      $display("FAIL single_b: got %h want %h", obs, {5'b01100, 3'd6, 16'h5A5A});
    end
    @(posedge clk); #1;
    B_Req = 1'b0;
    total++;
    if (rf[6] !== 16'h5A5A) begin
      bad++;
      $display("FAIL single_b_r6: got %h want 5a5a", rf[6]);
    end
  endtask

  task automatic test_idle();
    @(posedge clk); #1;
    A_DR = 3'd4; B_DR = 3'd4; A_Data = 16'hFFFF; B_Data = 16'hEEEE;
    @(negedge clk);
    total++;
    if (obs !== 24'h000000) begin
      bad++;
      $display("FAIL idle: got %h want %h", obs, 24'h000000);
    end
  endtask

  task automatic test_contend();
    logic [23:0] exp_a, exp_b;
    logic [23:0] exp_seq [4];
    exp_a = {5'b10100, 3'd1, 16'hAAAA};
    exp_b = {5'b01100, 3'd2, 16'hBBBB};
`ifdef ROUND_ROBIN_EN
    exp_seq = '{exp_a, exp_b, exp_a, exp_b};
`else
    exp_seq = '{exp_a, exp_a, exp_a, exp_a};
`endif
    @(posedge clk); #1;
    A_Req = 1'b1; A_DR = 3'd1; A_Data = 16'hAAAA;
    B_Req = 1'b1; B_DR = 3'd2; B_Data = 16'hBBBB;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_seq[k]) begin
        bad++;
        $display("FAIL contend_cycle%0d: got %h want %h", k, obs, exp_seq[k]);
      end
    end
    @(posedge clk); #1;
    A_Req = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== exp_b) begin
      bad++;
      $display("FAIL contend_b_alone: got %h want %h", obs, exp_b);
    end
    @(posedge clk); #1;
    B_Req = 1'b0;
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    A_Req = 1'b1; A_DR = 3'd5; A_Data = 16'h1111;
    B_Req = 1'b1; B_DR = 3'd5; B_Data = 16'h2222;
    @(negedge clk);
    total++;
    if (obs !== {5'b10101, 3'd5, 16'h1111}) begin
      bad++;
      $display("FAIL collision_a: got %h want %h", obs, {5'b10101, 3'd5, 16'h1111});
    end
    @(posedge clk); #1;
    A_Req = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== {5'b01100, 3'd5, 16'h2222}) begin
      bad++;
      $display("FAIL collision_b: got %h want %h", obs, {5'b01100, 3'd5, 16'h2222});
    end
    @(posedge clk); #1;
    B_Req = 1'b0;
    total++;
    if (rf[5] !== 16'h2222) begin
      bad++;
      $display("FAIL collision_r5: got %h want 2222", rf[5]);
    end
  endtask

  // Reset in ARB with both requests held: no grants during reset/clear, A wins on re-entry.
  task automatic test_reset_mid_arb();
    @(posedge clk); #1;
    Reset = 1'b1;
    A_Req = 1'b1; A_DR = 3'd1; A_Data = 16'hAAAA;
    B_Req = 1'b1; B_DR = 3'd2; B_Data = 16'hBBBB;
    @(negedge clk);
    total++;
    if (obs !== {5'b00110, 3'd0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_mid_arb: got %h want %h", obs, {5'b00110, 3'd0, 16'h0000});
    end
    @(posedge clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (obs !== {5'b00110, 3'(i), 16'h0000}) begin
        bad++;
        $display("FAIL held_clear%0d: got %h want %h", i, obs, {5'b00110, 3'(i), 16'h0000});
      end
    end
    @(negedge clk);
    total++;
    if (obs !== {5'b10100, 3'd1, 16'hAAAA}) begin
      bad++;
      $display("FAIL ptr_after_reset: got %h want %h", obs, {5'b10100, 3'd1, 16'hAAAA});
    end
    @(posedge clk); #1;
    A_Req = 1'b0; B_Req = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        B_Req = 1'b1; B_DR = 3'd7; B_Data = 16'h7777;
      end
      if (i == 4) Reset = 1'b1;
      @(negedge clk);
      total++;
      if (i < 4 && obs !== {5'b00110, 3'(i), 16'h0000}) begin
        bad++;
        $display("FAIL pre_pulse%0d: got %h want %h", i, obs, {5'b00110, 3'(i), 16'h0000});
      end else if (i == 4 && obs !== {5'b00110, 3'd0, 16'h0000}) begin
        bad++;
        $display("FAIL pulse_at_cnt4: got %h want %h", obs, {5'b00110, 3'd0, 16'h0000});
      end
      @(posedge clk); #1;
    end
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (obs !== {5'b00110, 3'(i), 16'h0000}) begin
        bad++;
        $display("FAIL restart_clear%0d: got %h want %h", i, obs, {5'b00110, 3'(i), 16'h0000});
      end
    end
    @(negedge clk);
    total++;
    if (obs !== {5'b01100, 3'd7, 16'h7777}) begin
      bad++;
      $display("FAIL b_on_arb_entry: got %h want %h", obs, {5'b01100, 3'd7, 16'h7777});
    end
    total++;
    if (rf[3] !== 16'h0000) begin
      bad++;
      $display("FAIL recleared_r3: got %h want 0000", rf[3]);
    end
    @(posedge clk); #1;
    B_Req = 1'b0;
    total++;
    if (rf[7] !== 16'h7777) begin
      bad++;
      $display("FAIL b_write_r7: got %h want 7777", rf[7]);
    end
  endtask

  initial begin
    Reset = 1'b1;
    rf_poison = 1'b1;
    A_Req = 1'b0; B_Req = 1'b0;
    A_DR = 3'd0; B_DR = 3'd0;
    A_Data = 16'h0000; B_Data = 16'h0000;
    test_reset();
    test_clear_seq();
    test_single_a();
    test_single_b();
    test_idle();
    test_contend();
    test_collision();
    test_reset_mid_arb();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 A_Req  input  1  requester A (CPU datapath) write request.
REQ-004 A_DR  input  3  requester A destination register index.
REQ-005 A_Data  input  16  requester A write data.
REQ-006 A_Gnt  output  1  requester A granted this cycle.
REQ-007 B_Req / B_DR / B_Data  input  1/3/16  requester B (debug port) request, index, data.
REQ-008 B_Gnt  output  1  requester B granted this cycle.
REQ-009 DR  output  3  destination select to register file.
REQ-010 Data_In  output  16  write data to register file.
REQ-011 LD_REG  output  1  register file write enable.
REQ-012 Busy  output  1  high while the post-reset clear sequence runs.
REQ-013 Collision  output  1  high in any ARB cycle where A_Req, B_Req both high and A_DR equals B_DR.

Function
REQ-014 FSM SHALL have two states: CLEAR and ARB.
REQ-015 CLEAR: 3-bit counter Cnt; outputs LD_REG=1, DR=Cnt, Data_In=16'h0000, A_Gnt=B_Gnt=0, Busy=1; Cnt increments each cycle.
REQ-016 CLEAR SHALL last exactly 8 cycles (Cnt 0..7), writing zero to R0..R7 in order; after Cnt=7 the FSM enters ARB and Cnt wraps to 0.
REQ-017 ARB: Busy=0; at most one of A_Gnt, B_Gnt high; grant is combinational from current Req inputs and priority pointer Ptr.
REQ-018 ARB, only one Req high: that requester granted in the same cycle.
REQ-019 ARB, both Req high: requester indicated by Ptr granted; other gets Gnt=0 and SHALL hold Req, DR, Data until granted.
REQ-020 ARB, no Req high: A_Gnt=B_Gnt=0, LD_REG=0, DR=3'b000, Data_In=16'h0000.
REQ-021 LD_REG SHALL equal A_Gnt OR B_Gnt in ARB; DR/Data_In SHALL be the granted requester's DR/Data.
REQ-022 Write latency: register file captures granted data at the rising edge ending the grant cycle (zero added cycles).
REQ-023 Handshake: a request is consumed by the cycle its Gnt is high; Req still high in the next cycle is a new request.
REQ-024 Collision is informational only; arbitration proceeds per REQ-019 and the losing write lands in a later cycle.
REQ-025 Requests arriving during CLEAR SHALL be ignored (no Gnt) and served on ARB entry if still held.

Reset
REQ-026 Reset high SHALL force state CLEAR, Cnt=0, Ptr=A at the next rising edge, regardless of current state.
REQ-027 Reset asserted mid-CLEAR SHALL restart the sequence at R0; reset mid-ARB SHALL abandon any pending request.
REQ-028 While Reset is high outputs follow CLEAR with Cnt=0: LD_REG=1, DR=0, Data_In=0, Busy=1, Gnt=0, Collision=0.

Configuration
REQ-029 Macro ROUND_ROBIN_EN defined: Ptr toggles to the non-granted requester after every contended grant (both Req high); uncontended grants leave Ptr unchanged.
REQ-030 ROUND_ROBIN_EN undefined: Ptr fixed to A (A strict priority); Ptr register omitted; B served only when A_Req=0.

Verification
REQ-031 Release Reset, no Req -> 8 cycles LD_REG=1, DR=0..7, Data_In=0, Busy=1; cycle 9 Busy=0, LD_REG=0; all registers read 16'h0000.
REQ-032 ARB, A_Req=1 A_DR=3 A_Data=16'h1234 for one cycle -> A_Gnt=1, LD_REG=1, DR=3 same cycle; R3 reads 16'h1234 next cycle.
REQ-033 ROUND_ROBIN_EN, both Req held 4 cycles (A_DR=1 data 16'hAAAA, B_DR=2 data 16'hBBBB) -> grants A,B,A,B; undefined -> A,A,A,A with B_Gnt=0.
REQ-034 Both Req, A_DR=B_DR=5 -> Collision=1; R5 ends with the later-granted requester's data.
REQ-035 Reset pulsed at Cnt=4 of CLEAR -> next cycle DR=0, Busy=1; full 8-cycle clear repeats.
REQ-036 B_Req=1 raised during CLEAR at Cnt=2 and held -> B_Gnt=0 until ARB entry, then B_Gnt=1 in first ARB cycle.
